// File: rtl/spi_pkg.sv
// Shared definitions for the SPI main and its memory-bridge subordinate.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MSG_W  = 2 + ADDR_W + DATA_W;   // 44-bit frame

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Phase lengths in sclk posedges
    localparam int SEND_LEN = 44;
    localparam int TURN_LEN = 1;
    localparam int RECV_LEN = 44;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TURN,
        RECV,
        DONE,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_shift44.sv
// Frame shift register shared by transmit and receive phases (MSB-first out, LSB in).
// Latency: one posedge per load/shift operation.
// Backpressure: none; load has priority over shifting, shift_in over shift_out.
// Ports: clk/rst, load + load_data, shift_out, shift_in + din, q (register contents).
module spi_shift44
    import spi_pkg::*;
#(
    parameter int W = MSG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_out,
    input  logic         shift_in,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_in) begin
            q <= {q[W-2:0], din};
        end else if (shift_out) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_main.sv
// SPI main: sends {op,addr,data} MSB-first, waits one turnaround cycle, reads a 44-bit reply.
// Latency: resp_valid on the 90th posedge after acceptance; next accept GAP_CYC+1 posedges later.
// Backpressure: req_ready is high only in IDLE; requests seen while busy are dropped, not queued.
// Ports: sclk/rst, host request (req_*), response (resp_*), busy, SPI pins (cs_n, mosi, miso).
module spi_main #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int GAP_CYC = 2
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    output logic [2+ADDR_W+DATA_W-1:0] resp_frame,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       cs_n,
    output logic                       mosi,
    input  logic                       miso
);
    import spi_pkg::*;

    localparam logic [6:0] GAP_RELOAD = 7'(GAP_CYC - 1);

    spi_state_t       state, state_nxt;
    logic [6:0]       cnt, cnt_nxt;
    spi_frame_t       frame_in, sent_frame, rx_frame;
    logic [MSG_W-1:0] shreg;
    logic             accept, sh_load, sh_out, sh_in, echo_err;

    assign accept = req_valid && (state == IDLE);

    // Write data is only meaningful for writes; everything else carries zeros.
    always_comb begin
        frame_in.op   = req_op;
        frame_in.addr = req_addr;
        frame_in.data = (req_op == OP_WRITE) ? req_wdata : '0;
    end

    // TX and RX never overlap, so one register serves both directions.
    spi_shift44 #(.W(MSG_W)) u_shift (
        .clk       (sclk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (frame_in),
        .shift_out (sh_out),
        .shift_in  (sh_in),
        .din       (miso),
        .q         (shreg)
    );

    // State register
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: one down-counter, reloaded with (phase length - 1) on entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SEND;
                    cnt_nxt   = 7'(SEND_LEN - 1);
                end
            end
            SEND: begin
                if (cnt == 7'd0) begin
                    state_nxt = TURN;
                    cnt_nxt   = 7'(TURN_LEN - 1);
                end else begin
                    cnt_nxt = cnt - 7'd1;
                end
            end
            TURN: begin
                if (cnt == 7'd0) begin
                    state_nxt = RECV;
                    cnt_nxt   = 7'(RECV_LEN - 1);
                end else begin
                    cnt_nxt = cnt - 7'd1;
                end
            end
            RECV: begin
                if (cnt == 7'd0) begin
                    state_nxt = DONE;
                    cnt_nxt   = 7'd0;
                end else begin
                    cnt_nxt = cnt - 7'd1;
                end
            end
            DONE: begin
                state_nxt = GAP;
                cnt_nxt   = GAP_RELOAD;
            end
            GAP: begin
                if (cnt == 7'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 7'd0;
                end else begin
                    cnt_nxt = cnt - 7'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 7'd0;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        sh_load   = accept;
        sh_out    = (state == SEND);
        sh_in     = (state == RECV);
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Reads only echo the header; a write must echo the whole frame.
    assign rx_frame = shreg;
    assign echo_err = (sent_frame.op == OP_WRITE)
                    ? (rx_frame != sent_frame)
                    : ({rx_frame.op, rx_frame.addr} != {sent_frame.op, sent_frame.addr});

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cs_n       <= 1'b1;
            resp_valid <= 1'b0;
            resp_frame <= '0;
            resp_err   <= 1'b0;
            sent_frame <= '0;
        end else begin
            // Select stays low from acceptance through the DONE cycle.
            cs_n       <= !(state_nxt inside {SEND, TURN, RECV, DONE});
            resp_valid <= (state == DONE);
            if (accept) begin
                sent_frame <= frame_in;
            end
            if (state == DONE) begin
                resp_frame <= shreg;
                resp_err   <= echo_err;
            end
        end
    end

    assign resp_rdata = resp_frame[DATA_W-1:0];

    // mosi changes half a cycle ahead of the subordinate's sampling posedge.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            mosi <= 1'b0;
        end else begin
            mosi <= (state == SEND) ? shreg[MSG_W-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_main.sv
`timescale 1ns/1ps
module tb_spi_main;
    import spi_pkg::*;

    localparam int GAP = 2;

    logic        sclk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_err, busy, cs_n, mosi, miso;
    logic [1:0]  req_op;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic [43:0] resp_frame;

    spi_main #(.ADDR_W(10), .DATA_W(32), .GAP_CYC(GAP)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_frame (resp_frame),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- subordinate stub with 1Kx32 memory ----------------
    logic [31:0] sub_mem [0:1023];
    logic [43:0] sub_rx, sub_tx, sub_last_rx;
    logic [1:0]  sub_o;
    logic [9:0]  sub_a;
    logic [31:0] sub_d;
    int          sub_k = 0;
    int          sub_flip = -1;

    always @(posedge sclk or posedge rst) begin
        if (rst || cs_n) begin
            sub_k = 0;
        end else begin
            sub_k++;
            if (sub_k <= 44) sub_rx = {sub_rx[42:0], mosi};
            if (sub_k == 44) sub_last_rx = sub_rx;
            if (sub_k == 45) begin
                {sub_o, sub_a, sub_d} = sub_rx;
                if (sub_o == OP_WRITE) begin
                    sub_mem[sub_a] = sub_d;
                    sub_tx = sub_rx;
                end else if (sub_o == OP_READ) begin
                    sub_tx = {sub_o, sub_a, sub_mem[sub_a]};
                end else begin
                    sub_tx = {sub_o, sub_a, 32'h0};
                end
                if (sub_flip >= 0) sub_tx[sub_flip] = ~sub_tx[sub_flip];
            end
        end
    end

    always @(negedge sclk or posedge rst) begin
        if (rst) miso = 1'b0;
        else if (sub_k >= 45 && sub_k <= 88) miso = sub_tx[88 - sub_k];
        else miso = 1'b0;
    end

    // ---------------- monitor ----------------
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;
    int fall_cyc = 0, rise_cyc = 0, rdy_bad = 0;
    logic busy_prev = 1'b0, cs_prev = 1'b1;
    logic [43:0] got_frame;
    logic [31:0] got_rdata;
    logic        got_err;

    always @(posedge sclk) cyc++;

    always @(negedge sclk) begin
        if (busy && !busy_prev) begin acc_cnt++; acc_cyc = cyc; end
        if (!cs_n && cs_prev) fall_cyc = cyc;
        if (cs_n && !cs_prev) rise_cyc = cyc;
        if (resp_valid) begin
            resp_cnt++; resp_cyc = cyc;
            got_frame = resp_frame; got_rdata = resp_rdata; got_err = resp_err;
        end
        if (req_ready == busy) rdy_bad++;
        if (!cs_n && req_ready) rdy_bad++;
        busy_prev = busy;
        cs_prev   = cs_n;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:1023];

    function automatic logic [43:0] exp_resp(input logic [1:0] op, input logic [9:0] a,
                                             input logic [31:0] d, input int flip);
        logic [43:0] r;
        if (op == OP_WRITE)     r = {op, a, d};
        else if (op == OP_READ) r = {op, a, ref_mem[a]};
        else                    r = {op, a, 32'h0};
        if (flip >= 0) r[flip] = ~r[flip];
        return r;
    endfunction

    task automatic txn(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                       input int flip, output logic done);
        int n0, t;
        n0 = resp_cnt;
        @(negedge sclk);
        sub_flip = flip; req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 400) begin @(negedge sclk); t++; end
        @(negedge sclk);
        req_valid = 1'b0;
        t = 0;
        while (resp_cnt == n0 && t < 400) begin @(negedge sclk); t++; end
        done = (resp_cnt != n0);
        if (done && op == OP_WRITE) ref_mem[a] = d;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          flip;
        logic [43:0] exp_frame;
        logic        exp_err;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [8];
        logic        done, ee;
        logic [1:0]  op;
        logic [9:0]  a;
        logic [31:0] d;
        logic [43:0] ef;
        int          flip, t, a0, n0, r1;

        tbl[0] = '{2'b01, 10'h010, 32'hDEADBEEF, -1, {2'b01, 10'h010, 32'hDEADBEEF}, 1'b0};
        tbl[1] = '{2'b00, 10'h010, 32'hFFFFFFFF, -1, {2'b00, 10'h010, 32'hDEADBEEF}, 1'b0};
        tbl[2] = '{2'b01, 10'h020, 32'h12345678, 35,
                   {2'b01, 10'h020, 32'h12345678} ^ (44'h1 << 35), 1'b1};
        tbl[3] = '{2'b00, 10'h020, 32'h0, -1, {2'b00, 10'h020, 32'h12345678}, 1'b0};
        tbl[4] = '{2'b00, 10'h010, 32'h0, 5, {2'b00, 10'h010, 32'hDEADBECF}, 1'b0};
        tbl[5] = '{2'b00, 10'h010, 32'h0, 40,
                   {2'b00, 10'h010, 32'hDEADBEEF} ^ (44'h1 << 40), 1'b1};
        tbl[6] = '{2'b11, 10'h3FF, 32'hAAAA5555, -1, {2'b11, 10'h3FF, 32'h0}, 1'b0};
        tbl[7] = '{2'b01, 10'h3FF, 32'h00C0FFEE, 0, {2'b01, 10'h3FF, 32'h00C0FFEF}, 1'b1};

        for (int i = 0; i < 1024; i++) begin sub_mem[i] = '0; ref_mem[i] = '0; end
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_frame", 64'(resp_frame), 64'd0);
        @(negedge sclk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].flip, done);
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'd1);
            chk($sformatf("tbl%0d_frame", i), 64'(got_frame), 64'(tbl[i].exp_frame));
            chk($sformatf("tbl%0d_rdata", i), 64'(got_rdata), 64'(tbl[i].exp_frame[31:0]));
            chk($sformatf("tbl%0d_err", i), 64'(got_err), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_sent", i), 64'(sub_last_rx),
                64'({tbl[i].op, tbl[i].addr, (tbl[i].op == OP_WRITE) ? tbl[i].wdata : 32'h0}));
            chk($sformatf("tbl%0d_latency", i), 64'(resp_cyc - acc_cyc), 64'd90);
            chk($sformatf("tbl%0d_cs_low", i), 64'(rise_cyc - fall_cyc - 1), 64'd89);
        end

        // Reset in the middle of a write frame
        a0 = acc_cnt; n0 = resp_cnt;
        @(negedge sclk);
        sub_flip = -1; req_op = OP_WRITE; req_addr = 10'h010; req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 400) begin @(negedge sclk); t++; end
        @(negedge sclk);
        req_valid = 1'b0;
        t = 0;
        while (acc_cnt == a0 && t < 10) begin @(negedge sclk); t++; end
        chk("rst_mid_accepted", 64'(acc_cnt), 64'(a0 + 1));
        t = 0;
        while (cyc < acc_cyc + 30 && t < 100) begin @(posedge sclk); #1; t++; end
        #6;
        chk("rst_mid_mosi_before", 64'(mosi), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_cs_n", 64'(cs_n), 64'd1);
        chk("rst_mid_mosi", 64'(mosi), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge sclk);
        rst = 1'b0;
        repeat (120) @(negedge sclk);
        chk("rst_mid_no_resp", 64'(resp_cnt), 64'(n0));
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        txn(OP_READ, 10'h010, 32'h0, -1, done);
        chk("rst_mid_readback_done", 64'(done), 64'd1);
        chk("rst_mid_readback", 64'(got_rdata), 64'hDEADBEEF);
        chk("rst_mid_readback_err", 64'(got_err), 64'd0);

        // Request pulse at k=50 of a running frame must be ignored
        a0 = acc_cnt; n0 = resp_cnt;
        @(negedge sclk);
        sub_flip = -1; req_op = OP_WRITE; req_addr = 10'h030; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 400) begin @(negedge sclk); t++; end
        @(negedge sclk);
        req_valid = 1'b0;
        t = 0;
        while (acc_cnt == a0 && t < 10) begin @(negedge sclk); t++; end
        t = 0;
        while (cyc < acc_cyc + 49 && t < 100) begin @(negedge sclk); t++; end
        req_op = OP_READ; req_addr = 10'h3FF; req_valid = 1'b1;
        @(negedge sclk);
        req_valid = 1'b0;
        t = 0;
        while (resp_cnt == n0 && t < 200) begin @(negedge sclk); t++; end
        chk("ign_latency", 64'(resp_cyc - acc_cyc), 64'd90);
        chk("ign_cs_low", 64'(rise_cyc - fall_cyc - 1), 64'd89);
        chk("ign_frame", 64'(got_frame), 64'({2'b01, 10'h030, 32'h0BADF00D}));
        repeat (110) @(negedge sclk);
        chk("ign_accepts", 64'(acc_cnt), 64'(a0 + 1));
        chk("ign_resps", 64'(resp_cnt), 64'(n0 + 1));
        ref_mem[10'h030] = 32'h0BADF00D;

        // Back-to-back with req_valid held high
        a0 = acc_cnt; n0 = resp_cnt;
        @(negedge sclk);
        sub_flip = -1; req_op = OP_WRITE; req_addr = 10'h020; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        t = 0;
        while (acc_cnt == a0 && t < 400) begin @(negedge sclk); t++; end
        req_op = OP_READ; req_wdata = 32'h0;
        t = 0;
        while (resp_cnt == n0 && t < 200) begin @(negedge sclk); t++; end
        r1 = rise_cyc;
        chk("b2b_first_frame", 64'(got_frame), 64'({2'b01, 10'h020, 32'h12345678}));
        t = 0;
        while (acc_cnt < a0 + 2 && t < 200) begin @(negedge sclk); t++; end
        req_valid = 1'b0;
        t = 0;
        while (resp_cnt < n0 + 2 && t < 200) begin @(negedge sclk); t++; end
        chk("b2b_second_rdata", 64'(got_rdata), 64'h12345678);
        chk("b2b_cs_gap", 64'(fall_cyc - r1 - 1), 64'(GAP));
        repeat (100) @(negedge sclk);
        chk("b2b_accepts", 64'(acc_cnt), 64'(a0 + 2));
        ref_mem[10'h020] = 32'h12345678;

        // Randomized traffic against the reference model
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 3));
            a    = 10'($urandom_range(0, 47));
            d    = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 43)) : -1;
            ef   = exp_resp(op, a, d, flip);
            ee   = (flip >= 0) && ((op == OP_WRITE) || (flip >= 32));
            txn(op, a, d, flip, done);
            chk($sformatf("rnd%0d_done", i), 64'(done), 64'd1);
            chk($sformatf("rnd%0d_frame", i), 64'(got_frame), 64'(ef));
            chk($sformatf("rnd%0d_err", i), 64'(got_err), 64'(ee));
            chk($sformatf("rnd%0d_sent", i), 64'(sub_last_rx),
                64'({op, a, (op == OP_WRITE) ? d : 32'h0}));
        end

        chk("ready_busy_consistency", 64'(rdy_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
